bus_mux_slaves: RTL and testbench
=================================

# bus_mux_slaves

Parametrised 1-master → SLAVES_NUM-slave request/acknowledge interconnect. It sits between the core data port and the memory and peripheral slaves. Decoding uses the top SEL_BITS of the address. Each transaction is registered and locked to one slave until that slave acknowledges. Unmapped addresses and slaves that stall past a timeout receive an error response, so the master can never hang.

## Interface
- N, 32: address/data width
- SEL_BITS, 2: address MSBs used as slave index (addr[N-1 -: SEL_BITS])
- SLAVES_NUM, 3: number of slaves, 1..2**SEL_BITS
- TIMEOUT, 16: max BUSY cycles without ack before abort, ≥2
- ERR_DATA, 32'hDEAD_BEEF: master_rdata value on error response

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- master_req  in  1  request, held with stable addr/cmd/wdata until master_ack
- master_addr  in  N  byte address
- master_cmd  in  1  0 read, 1 write
- master_wdata  in  N  write data
- master_ack  out  1  one-cycle response pulse
- master_rdata  out  N  read data, valid with master_ack
- master_err  out  1  error flag, valid with master_ack
- slave_req  out  SLAVES_NUM  per-slave request, one-hot or zero
- slave_addr  out  N  registered address, shared by all slaves
- slave_cmd  out  1  registered cmd, shared
- slave_wdata  out  N  registered wdata, shared
- slave_ack  in  SLAVES_NUM  per-slave ack pulse
- slave_rdata  in  SLAVES_NUM*N  flattened; slave i occupies [i*N +: N]

## Operation
- FSM states: IDLE, BUSY, RESP, ERR.
- IDLE: on master_req, latch addr/cmd/wdata into output registers and sel = addr[N-1 -: SEL_BITS].
  - sel < SLAVES_NUM → BUSY.
  - otherwise → ERR (decode error, no slave touched).
- BUSY: slave_req[sel]=1. Timeout counter increments each cycle.
  - slave_ack[sel]=1 → capture slave_rdata[sel] (reads and writes alike), err=0 → RESP.
  - Counter reaches TIMEOUT-1 with no ack → rdata=ERR_DATA, err=1 → RESP.
  - Ack and expiry in the same cycle: ack wins.
- ERR: rdata=ERR_DATA, err=1 → RESP. ERR is a one-cycle state.
- RESP: master_ack=1 for exactly one cycle with the captured rdata/err → IDLE. slave_req all zero.
- Acks from non-selected slaves, and any slave_ack outside BUSY (including late acks after a timeout), are ignored.
- master_req sampled during RESP is ignored. The next request is accepted only in IDLE.
- Reset values: master_ack=0, master_rdata=0, master_err=0, slave_req=0, slave_addr=0, slave_cmd=0, slave_wdata=0, state=IDLE, counter=0.
- Reset asserted mid-transaction aborts it. No ack is ever issued for the aborted request.

## Timing
- Request accepted in cycle t (IDLE, master_req=1) → slave_req[sel] high from t+1.
- slave_ack in cycle k → slave_req drops at k+1, master_ack at k+1. Minimum round trip: slave acks at t+1 → master_ack at t+2.
- Decode error: master_ack at t+2 (IDLE→ERR→RESP).
- Timeout: slave_req high for exactly TIMEOUT cycles (t+1..t+TIMEOUT), master_ack at t+TIMEOUT+1.
- Back-to-back throughput: one transaction per 3 cycles minimum.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package bus_mux_pkg: state enum (IDLE, BUSY, RESP, ERR), CMD_READ/CMD_WRITE constants, default ERR_DATA.
- Sub-module bus_timeout_cnt: $clog2(TIMEOUT)-bit counter with clear, enable, and an expire output one cycle before wrap. Instantiated once.
- slave_rdata selection is an indexed part-select on registered sel; no per-slave case statements.

## Test plan
Default parameters for all scenarios.
- Read slave 1: addr 32'h4000_0010, cmd 0; slave 1 acks 3 cycles after its req with rdata 32'h1234_5678 → slave_req=3'b010 for 3 cycles, master_ack one cycle later with rdata 32'h1234_5678, err 0.
- Write slave 0: addr 32'h0000_0004, wdata 32'hA5A5_A5A5; immediate ack → slave_wdata 32'hA5A5_A5A5, slave_cmd 1, master_ack at t+2, err 0.
- Unmapped: addr 32'hC000_0000 (sel 3) → slave_req stays 0, master_ack at t+2, rdata 32'hDEAD_BEEF, err 1.
- Timeout: slave 2 never acks → slave_req[2] high exactly 16 cycles, master_ack err 1. Slave 2 acks 2 cycles later → ignored, no extra master_ack.
- Robustness: rst pulsed while in BUSY → all outputs 0 the next cycle, no master_ack. Stray slave_ack[0] while slave 1 is selected → ignored. Ack coincident with timeout expiry → err 0, slave data returned.

Source files
------------

// File: rtl/bus_mux_pkg.sv
// Shared types and constants for the 1-master to N-slave request/acknowledge interconnect.
package bus_mux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    ERR
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_mux_slaves_if.sv
// Bundle of master-side and slave-side signals around the interconnect.
interface bus_mux_slaves_if #(
  parameter int N          = 32,
  parameter int SLAVES_NUM = 3
);

  logic                    master_req;
  logic [N-1:0]            master_addr;
  logic                    master_cmd;
  logic [N-1:0]            master_wdata;
  logic                    master_ack;
  logic [N-1:0]            master_rdata;
  logic                    master_err;
  logic [SLAVES_NUM-1:0]   slave_req;
  logic [N-1:0]            slave_addr;
  logic                    slave_cmd;
  logic [N-1:0]            slave_wdata;
  logic [SLAVES_NUM-1:0]   slave_ack;
  logic [SLAVES_NUM*N-1:0] slave_rdata;

  // master: the interconnect itself, which masters the slave bus and answers the core.
  modport master (
    input  master_req, master_addr, master_cmd, master_wdata, slave_ack, slave_rdata,
    output master_ack, master_rdata, master_err, slave_req, slave_addr, slave_cmd, slave_wdata
  );

  // slave: the environment, i.e. the core plus the attached slaves.
  modport slave (
    output master_req, master_addr, master_cmd, master_wdata, slave_ack, slave_rdata,
    input  master_ack, master_rdata, master_err, slave_req, slave_addr, slave_cmd, slave_wdata
  );

endinterface

// File: rtl/bus_timeout_cnt.sv
// Cycle counter that flags the last cycle before a stalled slave is abandoned.
module bus_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is updated with non-blocking assignments only,
  // so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_mux_slaves.sv
// Registered 1-master to SLAVES_NUM-slave interconnect with decode-error and timeout responses.
module bus_mux_slaves
  import bus_mux_pkg::*;
#(
  parameter int           N          = 32,
  parameter int           SEL_BITS   = 2,
  parameter int           SLAVES_NUM = 3,
  parameter int           TIMEOUT    = 16,
  parameter logic [N-1:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  bus_mux_slaves_if.master bus
);

  localparam logic [SEL_BITS:0]     SLV_LIM  = (SEL_BITS + 1)'(SLAVES_NUM);
  localparam logic [SLAVES_NUM-1:0] REQ_ONE  = SLAVES_NUM'(1);

  state_t                state, state_next;
  logic [SEL_BITS-1:0]   sel;
  logic [SEL_BITS-1:0]   sel_in;
  logic                  mapped;
  logic                  ack_sel;
  logic                  expire;
  logic                  accept;
  logic                  cap_ok;
  logic                  cap_err;
  logic                  cnt_clr;
  logic                  cnt_en;
  logic [SLAVES_NUM-1:0] req_next;

  assign sel_in  = bus.master_addr[N-1 -: SEL_BITS];
  assign mapped  = {1'b0, sel_in} < SLV_LIM;
  assign ack_sel = bus.slave_ack[sel];

  bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    cap_ok     = 1'b0;
    cap_err    = 1'b0;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;
    req_next   = '0;
    unique case (state)
      IDLE: begin
        if (bus.master_req) begin
          accept = 1'b1;
          if (mapped) begin
            state_next = BUSY;
            req_next   = REQ_ONE << sel_in;
          end else begin
            state_next = ERR;
          end
        end
      end
      BUSY: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        // A real ack beats a coincident expiry.
        if (ack_sel) begin
          cap_ok     = 1'b1;
          state_next = RESP;
        end else if (expire) begin
          cap_err    = 1'b1;
          state_next = RESP;
        end else begin
          req_next = bus.slave_req;
        end
      end
      ERR: begin
        cap_err    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // All outputs are flops; nothing on the input side reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel              <= '0;
      bus.slave_addr   <= '0;
      bus.slave_cmd    <= 1'b0;
      bus.slave_wdata  <= '0;
      bus.slave_req    <= '0;
      bus.master_ack   <= 1'b0;
      bus.master_rdata <= '0;
      bus.master_err   <= 1'b0;
    end else begin
      if (accept) begin
        sel             <= sel_in;
        bus.slave_addr  <= bus.master_addr;
        bus.slave_cmd   <= bus.master_cmd;
        bus.slave_wdata <= bus.master_wdata;
      end
      bus.slave_req  <= req_next;
      bus.master_ack <= (state_next == RESP);
      if (cap_ok) begin
        bus.master_rdata <= bus.slave_rdata[sel*N +: N];
        bus.master_err   <= 1'b0;
      end else if (cap_err) begin
        bus.master_rdata <= ERR_DATA;
        bus.master_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_mux_slaves.sv
// Randomized transaction-level bench for bus_mux_slaves with directed corner cases.
module tb_bus_mux_slaves;
  import bus_mux_pkg::*;

  localparam int N          = 32;
  localparam int SEL_BITS   = 2;
  localparam int SLAVES_NUM = 3;
  localparam int TIMEOUT    = 16;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bus_mux_slaves_if #(.N(N), .SLAVES_NUM(SLAVES_NUM)) bus ();

  bus_mux_slaves #(
    .N          (N),
    .SEL_BITS   (SEL_BITS),
    .SLAVES_NUM (SLAVES_NUM),
    .TIMEOUT    (TIMEOUT),
    .ERR_DATA   (ERR_WORD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: d is the slave_req cycle on which the slave acks.
  function automatic int model_latency(input int sel, input int d);
    if (sel >= SLAVES_NUM) return 2;
    if (d <= TIMEOUT)      return d + 1;
    return TIMEOUT + 1;
  endfunction

  function automatic int model_req_cycles(input int sel, input int d);
    if (sel >= SLAVES_NUM) return 0;
    return (d < TIMEOUT) ? d : TIMEOUT;
  endfunction

  function automatic bit model_err(input int sel, input int d);
    return (sel >= SLAVES_NUM) || (d > TIMEOUT);
  endfunction

  task automatic run_txn(input logic [31:0] addr, input logic cmd, input logic [31:0] wdata,
                         input int d, input logic [31:0] ack_data, input bit stray,
                         input string tag);
    int                    sel;
    int                    req_cycles;
    int                    lat;
    bit                    bad_req;
    bit                    acked;
    logic [SLAVES_NUM-1:0] onehot;
    logic [31:0]           exp_rdata;
    logic [31:0]           got_rdata;
    logic                  got_err;
    sel        = int'(addr[31:30]);
    req_cycles = 0;
    lat        = 0;
    bad_req    = 1'b0;
    acked      = 1'b0;
    onehot     = '0;
    if (sel < SLAVES_NUM) onehot[sel] = 1'b1;
    exp_rdata  = ERR_WORD;
    got_rdata  = '0;
    got_err    = 1'b0;

    @(negedge clk);
    bus.master_req   = 1'b1;
    bus.master_addr  = addr;
    bus.master_cmd   = cmd;
    bus.master_wdata = wdata;
    @(posedge clk);
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      bus.slave_ack   = '0;
      bus.slave_rdata = {$urandom, $urandom, $urandom};
      if (bus.master_ack) begin
        lat       = n;
        got_rdata = bus.master_rdata;
        got_err   = bus.master_err;
        if (bus.slave_req != '0) bad_req = 1'b1;
        bus.master_req = 1'b0;
      end else begin
        if (onehot != '0 && bus.slave_req == onehot) req_cycles++;
        else if (bus.slave_req != '0)               bad_req = 1'b1;
        if (n == 1) begin
          check({tag, ".slave_addr"},  64'(bus.slave_addr),  64'(addr));
          check({tag, ".slave_cmd"},   64'(bus.slave_cmd),   64'(cmd));
          check({tag, ".slave_wdata"}, 64'(bus.slave_wdata), 64'(wdata));
        end
        if (sel < SLAVES_NUM && !acked && bus.slave_req[sel] && req_cycles == d) begin
          bus.slave_ack[sel]          = 1'b1;
          bus.slave_rdata[sel*N +: N] = ack_data;
          exp_rdata                   = ack_data;
          acked                       = 1'b1;
        end
        if (stray && n == 2 && sel == 1) bus.slave_ack[0] = 1'b1;
      end
    end
    bus.master_req = 1'b0;
    bus.slave_ack  = '0;

    check({tag, ".latency"},    64'(lat),        64'(model_latency(sel, d)));
    check({tag, ".req_cycles"}, 64'(req_cycles), 64'(model_req_cycles(sel, d)));
    check({tag, ".req_onehot"}, 64'(bad_req),    64'(0));
    check({tag, ".err"},        64'(got_err),    64'(model_err(sel, d)));
    check({tag, ".rdata"},      64'(got_rdata),
          64'(model_err(sel, d) ? ERR_WORD : exp_rdata));

    @(negedge clk);
    check({tag, ".ack_pulse"}, 64'(bus.master_ack), 64'(0));
  endtask

  task automatic watch_no_ack(input int cycles, input string tag);
    int acks;
    acks = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.master_ack) acks++;
    end
    check(tag, 64'(acks), 64'(0));
  endtask

  initial begin
    rst              = 1'b1;
    bus.master_req   = 1'b0;
    bus.master_addr  = '0;
    bus.master_cmd   = CMD_READ;
    bus.master_wdata = '0;
    bus.slave_ack    = '0;
    bus.slave_rdata  = '0;
    repeat (3) @(negedge clk);
    check("rst.master_ack",   64'(bus.master_ack),   64'(0));
    check("rst.master_rdata", 64'(bus.master_rdata), 64'(0));
    check("rst.master_err",   64'(bus.master_err),   64'(0));
    check("rst.slave_req",    64'(bus.slave_req),    64'(0));
    check("rst.slave_addr",   64'(bus.slave_addr),   64'(0));
    check("rst.slave_cmd",    64'(bus.slave_cmd),    64'(0));
    check("rst.slave_wdata",  64'(bus.slave_wdata),  64'(0));
    rst = 1'b0;

    run_txn(32'h4000_0010, CMD_READ,  $urandom,     3,   32'h1234_5678, 1'b0, "rd_s1");
    run_txn(32'h0000_0004, CMD_WRITE, 32'hA5A5_A5A5, 1,  $urandom,      1'b0, "wr_s0");
    run_txn(32'hC000_0000, CMD_READ,  $urandom,     1,   $urandom,      1'b0, "unmapped");

    run_txn(32'h8000_0000, CMD_READ,  $urandom,     1000, $urandom,     1'b0, "timeout");
    @(negedge clk);
    bus.slave_ack[2] = 1'b1;
    @(negedge clk);
    bus.slave_ack = '0;
    watch_no_ack(6, "late_ack");

    run_txn(32'h4000_0020, CMD_READ,  $urandom,     5,   $urandom,      1'b1, "stray_ack");
    run_txn(32'h4000_0000, CMD_READ,  $urandom,     TIMEOUT, 32'h0BAD_CAFE, 1'b0, "ack_at_expiry");
    run_txn(32'h8000_0040, CMD_READ,  $urandom,     TIMEOUT + 1, $urandom, 1'b0, "ack_after_expiry");

    for (int i = 0; i < 40; i++) begin
      run_txn($urandom, logic'($urandom_range(0, 1)), $urandom, $urandom_range(1, 20),
              $urandom, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a BUSY transaction must abort it silently.
    @(negedge clk);
    bus.master_req  = 1'b1;
    bus.master_addr = 32'h4000_0008;
    bus.master_cmd  = CMD_READ;
    repeat (3) @(negedge clk);
    check("busy.slave_req", 64'(bus.slave_req), 64'(3'b010));
    rst            = 1'b1;
    bus.master_req = 1'b0;
    @(negedge clk);
    check("midrst.master_ack",   64'(bus.master_ack),   64'(0));
    check("midrst.master_rdata", 64'(bus.master_rdata), 64'(0));
    check("midrst.master_err",   64'(bus.master_err),   64'(0));
    check("midrst.slave_req",    64'(bus.slave_req),    64'(0));
    check("midrst.slave_addr",   64'(bus.slave_addr),   64'(0));
    check("midrst.slave_cmd",    64'(bus.slave_cmd),    64'(0));
    check("midrst.slave_wdata",  64'(bus.slave_wdata),  64'(0));
    rst = 1'b0;
    bus.slave_ack[1] = 1'b1;
    @(negedge clk);
    bus.slave_ack = '0;
    watch_no_ack(20, "midrst.no_ack");

    run_txn(32'h4000_0044, CMD_WRITE, $urandom, 2, $urandom, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
